serial_input_capture: RTL

Receiving end of the 4-wire serial output link: samples `ser_in` on rising edges of `ser_clk` while `cs_n` is low and assembles 32-bit MSB-first words. It is clocked by the 32 MHz system clock, with all link inputs synchronised into that domain. Each completed word is presented on a parallel port and streamed to the FT2 FIFO as four bytes through the FT245-style write strobe. It closes the loop board-to-host, so host-issued words can be checked after a round trip.

---
 rtl/serial_input_capture.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/serial_input_capture.sv
`timescale 1ns/1ps
// Purpose: deserialise 32-bit MSB-first words from ser_clk/ser_in/cs_n, stream each to an FT245-style FIFO as 4 bytes.
// Latency: word_valid SYNC_STAGES+1 cycles after the first edge sampling ser_clk high for bit 32; 1+WR_LOW_CYCLES+1+1 cycles per byte.
// Backpressure: ft2_txe_n_in high stalls the writer; a word completing while the writer is busy is dropped (overflow).
// Option: define SER_RX_ERR_CNT_EN to add the saturating err_count output.
module serial_input_capture #(
    parameter int SYNC_STAGES   = 2,
    parameter int WR_LOW_CYCLES = 2
) (
    input  logic        clk_32,
    input  logic        rst,
    input  logic        ser_in,
    input  logic        ser_clk,
    input  logic        cs_n,
    input  logic        ft2_txe_n_in,
    output logic [7:0]  ft2_d_out,
    output logic        ft2_wr_n_out,
    output logic [31:0] word_out,
    output logic        word_valid,
    output logic        frame_err,
    output logic        overflow,
`ifdef SER_RX_ERR_CNT_EN
    output logic [7:0]  err_count,
`endif
    output logic        busy
);

    localparam logic [2:0] LOW_LAST = 3'(WR_LOW_CYCLES - 1);

    typedef enum logic {RX_IDLE, RX_SHIFT} rx_state_t;
    typedef enum logic [2:0] {W_IDLE, W_WAIT, W_SETUP, W_STROBE, W_HOLD} w_state_t;

    // Synchroniser chains; equal depth keeps the three link signals phase-aligned.
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] sdat_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [1:0]             txe_sync;
    logic                   sclk_prev;

    logic sclk_s, sdat_s, cs_s, txe_s, rise;

    rx_state_t rx_state, rx_next;
    w_state_t  w_state, w_next;

    // shreg holds the first 31 bits; bit 32 goes straight into cap with them.
    logic [30:0] shreg;
    logic [31:0] cap;
    logic [5:0]  bit_cnt;
    logic        extra;
    logic        pending;

    logic shift_en, last_bit, extra_hit, frame_end, frame_bad, load, drop;

    logic [31:0] hold;
    logic [1:0]  byte_idx;
    logic [2:0]  low_cnt;

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign sdat_s = sdat_sync[SYNC_STAGES-1];
    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign txe_s  = txe_sync[1];
    assign rise   = sclk_s & ~sclk_prev;

    // Input synchronisers plus the previous ser_clk value for edge detection.
    always_ff @(posedge clk_32) begin
        if (rst) begin
            sclk_sync <= '0;
            sdat_sync <= '0;
            cs_sync   <= '1;
            txe_sync  <= 2'b11;
            sclk_prev <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], ser_clk};
            sdat_sync <= {sdat_sync[SYNC_STAGES-2:0], ser_in};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
            txe_sync  <= {txe_sync[0], ft2_txe_n_in};
            sclk_prev <= sclk_s;
        end
    end

    // Receive FSM state register.
    always_ff @(posedge clk_32) begin
        if (rst) rx_state <= RX_IDLE;
        else     rx_state <= rx_next;
    end

    // Receive FSM next state: frame is bounded by synchronised cs_n.
    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE:  if (!cs_s) rx_next = RX_SHIFT;
            RX_SHIFT: if (cs_s)  rx_next = RX_IDLE;
            default:             rx_next = RX_IDLE;
        endcase
    end

    // Receive FSM decode; a bit arriving with cs_n deassert is taken before the frame is judged.
    always_comb begin
        shift_en  = (rx_state == RX_SHIFT) && rise && (bit_cnt < 6'd32);
        last_bit  = shift_en && (bit_cnt == 6'd31);
        extra_hit = (rx_state == RX_SHIFT) && rise && (bit_cnt == 6'd32);
        frame_end = (rx_state == RX_SHIFT) && cs_s;
        frame_bad = frame_end && (((bit_cnt != 6'd32) && !last_bit) || extra || extra_hit);
        load      = pending && !busy;
        drop      = pending && busy;
    end

    // Receive datapath: shift bits, hand finished words to the writer, raise status pulses.
    always_ff @(posedge clk_32) begin
        if (rst) begin
            shreg      <= '0;
            cap        <= '0;
            bit_cnt    <= '0;
            extra      <= 1'b0;
            pending    <= 1'b0;
            word_out   <= '0;
            word_valid <= 1'b0;
            frame_err  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            frame_err  <= 1'b0;
            overflow   <= 1'b0;
            pending    <= 1'b0;
            if ((rx_state == RX_IDLE) && !cs_s) begin
                shreg   <= '0;
                bit_cnt <= '0;
                extra   <= 1'b0;
            end
            if (shift_en) begin
                shreg   <= {shreg[29:0], sdat_s};
                bit_cnt <= bit_cnt + 6'd1;
            end
            if (last_bit) begin
                cap     <= {shreg, sdat_s};
                pending <= 1'b1;
            end
            if (extra_hit) extra     <= 1'b1;
            if (frame_bad) frame_err <= 1'b1;
            if (load) begin
                word_out   <= cap;
                word_valid <= 1'b1;
            end
            if (drop) overflow <= 1'b1;
        end
    end

    // Byte-writer FSM state register.
    always_ff @(posedge clk_32) begin
        if (rst) w_state <= W_IDLE;
        else     w_state <= w_next;
    end

    // Byte-writer next state: wait for FIFO space, set up data, strobe, hold.
    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:   if (load) w_next = W_WAIT;
            W_WAIT:   if (!txe_s) w_next = W_SETUP;
            W_SETUP:  w_next = W_STROBE;
            W_STROBE: if (low_cnt == LOW_LAST) w_next = W_HOLD;
            W_HOLD:   w_next = (byte_idx == 2'd3) ? W_IDLE : W_WAIT;
            default:  w_next = W_IDLE;
        endcase
    end

    // Byte-writer datapath: holding register, byte index, strobe width counter, busy flag.
    always_ff @(posedge clk_32) begin
        if (rst) begin
            hold     <= '0;
            byte_idx <= '0;
            low_cnt  <= '0;
            busy     <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: if (load) begin
                    hold     <= cap;
                    byte_idx <= 2'd0;
                    busy     <= 1'b1;
                end
                W_SETUP:  low_cnt <= '0;
                W_STROBE: low_cnt <= low_cnt + 3'd1;
                W_HOLD: begin
                    if (byte_idx == 2'd3) busy <= 1'b0;
                    else                  byte_idx <= byte_idx + 2'd1;
                end
                default: ;
            endcase
        end
    end

    // Byte-writer outputs: data valid from setup through hold, strobe low only in W_STROBE.
    always_comb begin
        ft2_wr_n_out = (w_state != W_STROBE);
        ft2_d_out    = 8'h00;
        if ((w_state == W_SETUP) || (w_state == W_STROBE) || (w_state == W_HOLD)) begin
            case (byte_idx)
                2'd0:    ft2_d_out = hold[31:24];
                2'd1:    ft2_d_out = hold[23:16];
                2'd2:    ft2_d_out = hold[15:8];
                default: ft2_d_out = hold[7:0];
            endcase
        end
    end

`ifdef SER_RX_ERR_CNT_EN
    logic [8:0] err_sum;
    assign err_sum = {1'b0, err_count} + 9'(frame_err) + 9'(overflow);

    // Saturating count of error pulses; two simultaneous pulses add two.
    always_ff @(posedge clk_32) begin
        if (rst)                err_count <= '0;
        else if (err_sum > 9'd255) err_count <= 8'hFF;
        else                    err_count <= err_sum[7:0];
    end
`endif

endmodule
